sequence_generator: RTL
=======================

// Module: sequence_generator
// PURPOSE
//   Serial pattern transmitter: the driving end of the 1-bit serial stream our
//   sequence detectors consume. On a start pulse it latches a PATTERN_W-bit pattern,
//   a repeat count and a gap length. It then shifts the pattern out MSB-first,
//   one bit per clk, repeat_cnt times, with gap_len idle bits between repetitions.
//   Used to drive detector inputs in system tests and on-chip self-check.
// PARAMETERS
//   PATTERN_W  4   pattern length in bits (>=2)
//   CNT_W      4   width of repeat_cnt
//   GAP_W      4   width of gap_len
// PORTS
//   clk         in   1          rising-edge clock, single clock domain
//   rst         in   1          synchronous reset, active-low (rst==0 resets on clk edge)
//   start       in   1          request; sampled only in IDLE
//   pattern     in   PATTERN_W  bits to send, MSB transmitted first
//   repeat_cnt  in   CNT_W      number of pattern transmissions; 0 treated as 1
//   gap_len     in   GAP_W      idle bits inserted between repetitions (not after last)
//   out         out  1          serial data, registered
//   out_valid   out  1          1 while out carries pattern or gap bits
//   busy        out  1          1 in SEND and GAP
//   done        out  1          single-cycle pulse after final bit
// BEHAVIOUR
//   - All outputs registered. Reset (rst==0 at an edge): state=IDLE; out=0, out_valid=0,
//     busy=0, done=0; all internal counters and latched config cleared. Reset applies
//     mid-stream: the remaining bits are discarded, no done pulse.
//   - FSM: IDLE -> SEND -> (GAP -> SEND)* -> DONE -> IDLE.
//   - IDLE: out=0, out_valid=0. If start=1 at edge N, then from edge N:
//     latch pattern/repeat_cnt/gap_len; enter SEND; out=pattern[PATTERN_W-1];
//     out_valid=1; busy=1. Latency: the first bit is visible in the cycle after start is sampled.
//   - SEND: one bit per cycle, bit index counts PATTERN_W-1 down to 0.
//     After bit 0: decrement the remaining-repeat counter.
//       remaining>0 and gap_len>0  -> GAP
//       remaining>0 and gap_len==0 -> SEND again, MSB next cycle (no bubble)
//       remaining==0               -> DONE
//   - GAP: exactly gap_len cycles; out=0 (see CONFIGURATION), out_valid=1, busy=1; then SEND.
//   - DONE: exactly one cycle; done=1, busy=0, out_valid=0, out=0; then IDLE.
//   - start is ignored outside IDLE (including DONE). Port changes after latch have no effect.
//   - Total cycles from start-sample to done: R*PATTERN_W + (R-1)*gap_len, +1 for the
//     DONE cycle, where R = max(repeat_cnt,1).
//   - Counters: bit index $clog2(PATTERN_W) bits; repeat counter CNT_W bits; gap
//     counter GAP_W bits. No wrap: each counter is reloaded at its phase entry.
//   - Max repeat_cnt (2^CNT_W-1) and max gap_len must be supported without overflow.
// CONFIGURATION
//   SEQ_GEN_PRBS_FILL_EN defined: gap bits come from a PRBS-7 LFSR (x^7+x^6+1).
//     The LFSR seeds to 7'h7F on reset and advances only in GAP cycles, and out = LFSR[0].
//     This exercises detector false-match and overlap handling.
//   Not defined: gap bits are constant 0; no LFSR logic is synthesized.
// TESTING
//   1. pattern=4'b1011, repeat=1, gap=0, start pulse at edge 0 -> out=1,0,1,1 in cycles 1-4,
//      out_valid=1 for cycles 1-4; done=1 in cycle 5 only; busy=0 from cycle 5.
//   2. pattern=4'b1011, repeat=2, gap=0 -> out 1,0,1,1,1,0,1,1 back-to-back, done in
//      cycle 9; downstream detector asserts twice.
//   3. pattern=4'b1011, repeat=2, gap=2 -> out 1,0,1,1,0,0,1,0,1,1 with out_valid=1
//      throughout, done in cycle 11.
//   4. start re-pulsed in cycle 2 and in the DONE cycle, and pattern changed mid-stream ->
//      both ignored, stream unchanged; start in the cycle after DONE is accepted.
//   5. rst=0 at the cycle-3 edge of case 1 -> all outputs 0 next cycle, no done; a new
//      start afterwards produces a full clean sequence. repeat_cnt=0 -> one transmission.
//   6. SEQ_GEN_PRBS_FILL_EN, repeat=2, gap=3 -> gap bits equal the first 3 PRBS-7 outputs
//      from seed 7'h7F (checked against the bench model); pattern bits are unaffected.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with idle gaps.
// Optional feature macro: SEQ_GEN_PRBS_FILL_EN (gap bits from a PRBS-7 LFSR instead of 0).
module sequence_generator #(
    parameter int unsigned PATTERN_W = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned GAP_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [CNT_W-1:0]     repeat_cnt,
    input  logic [GAP_W-1:0]     gap_len,
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned IDX_W = $clog2(PATTERN_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PATTERN_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t               state;
    logic [PATTERN_W-1:0] pat_q;
    logic [IDX_W-1:0]     bit_idx;   // index of the bit currently on out
    logic [CNT_W-1:0]     rem_q;     // transmissions still owed after the current one
    logic [GAP_W-1:0]     gap_q;
    logic [GAP_W-1:0]     gap_cnt;   // gap bits still owed after the current one
    logic [IDX_W-1:0]     idx_nxt;
    logic                 gap_bit;

    assign idx_nxt = bit_idx - IDX_W'(1);

`ifdef SEQ_GEN_PRBS_FILL_EN
    logic [6:0] lfsr;
    logic       gap_take;

    // LFSR steps once per emitted gap bit, so gaps walk the PRBS-7 sequence
    assign gap_take = ((state == SEND) && (bit_idx == '0) && (rem_q != '0) && (gap_q != '0))
                   || ((state == GAP) && (gap_cnt != '0));
    assign gap_bit  = lfsr[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= 7'h7F;
        end else if (gap_take) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
`else
    assign gap_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            bit_idx   <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q     <= pattern;
                        rem_q     <= (repeat_cnt == '0) ? '0 : repeat_cnt - CNT_W'(1);
                        gap_q     <= gap_len;
                        bit_idx   <= IDX_MSB;
                        out       <= pattern[PATTERN_W-1];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bit_idx != '0) begin
                        bit_idx <= idx_nxt;
                        out     <= pat_q[idx_nxt];
                    end else if (rem_q != '0) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (gap_q != '0) begin
                            gap_cnt <= gap_q - GAP_W'(1);
                            out     <= gap_bit;
                            state   <= GAP;
                        end else begin
                            bit_idx <= IDX_MSB;
                            out     <= pat_q[PATTERN_W-1];
                        end
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        out     <= gap_bit;
                    end else begin
                        bit_idx <= IDX_MSB;
                        out     <= pat_q[PATTERN_W-1];
                        state   <= SEND;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
